setup_hold_monitor: RTL and testbench
=====================================

# setup_hold_monitor

Synchronous checker for the data/enable pair that drives a level-sensitive D latch. It oversamples the asynchronous `d` and `g` waveforms with a fast clock. For every latch closing edge (falling `g`), it measures the setup margin (cycles from the last `d` change to `g` falling) and the hold margin (cycles from `g` falling to the next `d` change). It flags margins below programmable minimums. It sits at the receiving end of the pulse-generator/latch bench and replaces waveform inspection with a measured pass/fail.

## Interface
- `CNT_W`, 8, width of the margin counters; counts saturate at 2^CNT_W-1.
- `SETUP_MIN`, 4, minimum legal setup margin in clk cycles.
- `HOLD_MIN`, 4, minimum legal hold margin in clk cycles; also the length of the hold observation window.
- `SYNC_STAGES`, 2, synchronizer depth for `d` and `g` (≥2).
- `VCNT_W`, 16, width of the violation counter.

Ports:
- `clk`  in  1  sampling clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `d`  in  1  latch data, asynchronous to `clk`.
- `g`  in  1  latch enable, asynchronous to `clk`; the latch is transparent while high and captures on the fall.
- `meas_valid`  out  1  one-cycle pulse; the measurement outputs below are valid this cycle.
- `setup_cnt`  out  CNT_W  setup margin of the last window.
- `hold_cnt`  out  CNT_W  hold margin of the last window.
- `setup_viol`  out  1  pulse with `meas_valid` when `setup_cnt < SETUP_MIN`.
- `hold_viol`  out  1  pulse with `meas_valid` when `hold_cnt < HOLD_MIN`.
- `cap_val`  out  1  synchronized `d` value at the closing edge, i.e. the value the latch captured.
- `viol_count`  out  VCNT_W  saturating count of windows with any violation.

## Operation
- `d` and `g` each pass through a SYNC_STAGES flop chain and then a one-flop edge detector. Both paths have identical delay, so relative timing is preserved.
- `d_edge` = synchronized `d` differs from its previous sample. `g_rise` and `g_fall` are defined likewise.
- Setup counter (internal):
  - Clears to 0 on `d_edge` and otherwise increments, saturating.
  - Runs in every state.
  - Reset value is all ones (no edge seen means infinite margin).
- FSM states are IDLE, OPEN and HOLD. Reset state is IDLE.
  - IDLE: on `g_rise`, go to OPEN.
  - OPEN: on `g_fall`, latch `setup_cnt` from the counter value and `cap_val` from the pre-edge synchronized `d`. Clear the hold counter and go to HOLD.
    - If `d_edge` and `g_fall` coincide, the setup margin is 0.
  - HOLD: the hold counter increments each cycle. The window closes on the first of these events:
    - `d_edge` at hold count k: `hold_cnt` = k.
    - Count reaches HOLD_MIN: `hold_cnt` = HOLD_MIN, a pass.
    - `g_rise` at hold count k: `hold_cnt` = k, evaluated normally; the next state is OPEN, not IDLE.
  - On window close: pulse `meas_valid` and the viol flags, and increment `viol_count` if either flag is set (saturating at all ones). The next state is IDLE, or OPEN if closed by `g_rise`.
- A `g_fall` seen in IDLE (glitch or a start-up with `g` high) is ignored. No measurement is produced.

## Timing
- Reset values:
  - `meas_valid`, `setup_viol`, `hold_viol`, `cap_val`, `setup_cnt`, `hold_cnt`, `viol_count` are all 0.
  - Synchronizer flops are 0.
  - FSM is in IDLE; setup counter is all ones.
- Reset asserted mid-window: the window is discarded and no `meas_valid` is produced.
- Input-to-detect latency is SYNC_STAGES+1 clk cycles.
- `meas_valid` asserts 1 cycle after the closing event is detected. `setup_cnt`, `hold_cnt` and `cap_val` hold their values until the next `meas_valid`.
- Margins are quantized to ±1 clk cycle because of asynchronous sampling. The bench drives inputs synchronously to avoid ambiguity.

## Structure
- Package `setup_hold_pkg` holds:
  - the state enum (IDLE, OPEN, HOLD);
  - default constants for CNT_W, SETUP_MIN, HOLD_MIN, SYNC_STAGES and VCNT_W.
- Sub-module `sync_edge` (SYNC_STAGES synchronizer plus rise/fall/any-edge outputs) is instantiated twice, once for `d` and once for `g`.

## Test plan
- Reset asserted during HOLD → all outputs 0 next cycle, no `meas_valid`; after release, `g_rise` is still required before any measurement.
- `d` toggles 10 cycles before `g` falls and stays stable 20 cycles → one `meas_valid`, `setup_cnt`=10, `hold_cnt`=4, no viol, `viol_count`=0, `cap_val`=new `d`.
- `d` toggles in the same cycle `g` falls → `setup_cnt`=0, `setup_viol`=1, `hold_cnt`=4, `viol_count`=1.
- `d` toggles 2 cycles after `g` falls → `hold_cnt`=2, `hold_viol`=1, `setup_viol`=0, `viol_count` increments by 1.
- `d` constant for 300 cycles, then a full `g` pulse → `setup_cnt`=255 (saturated), no viol.
- `g` rises again 2 cycles after its fall with `d` static → `hold_cnt`=2, `hold_viol`=1, FSM goes to OPEN; the next `g_fall` produces a second measurement.

Source files
------------

// File: rtl/setup_hold_pkg.sv
// Shared state encoding and default parameters for the latch setup/hold monitor.
package setup_hold_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        HOLD
    } state_e;

    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_SETUP_MIN   = 4;
    localparam int unsigned DEF_HOLD_MIN    = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_VCNT_W      = 16;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous level, followed by a one-flop
// edge detector. prev_o is the synchronized level one cycle before the edge.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic prev_o,
    output logic rise_o,
    output logic fall_o,
    output logic edge_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              level;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level  = sync_q[STAGES-1];
    assign prev_o = prev_q;
    assign rise_o = level & ~prev_q;
    assign fall_o = ~level & prev_q;
    assign edge_o = level ^ prev_q;

endmodule

// File: rtl/setup_hold_monitor.sv
// Measures setup/hold margins of d around each falling edge of g and flags
// margins below SETUP_MIN / HOLD_MIN, counting violating windows.
module setup_hold_monitor
    import setup_hold_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SETUP_MIN   = DEF_SETUP_MIN,
    parameter int unsigned HOLD_MIN    = DEF_HOLD_MIN,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned VCNT_W      = DEF_VCNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d,
    input  logic              g,
    output logic              meas_valid,
    output logic [CNT_W-1:0]  setup_cnt,
    output logic [CNT_W-1:0]  hold_cnt,
    output logic              setup_viol,
    output logic              hold_viol,
    output logic              cap_val,
    output logic [VCNT_W-1:0] viol_count
);

    logic d_prev, d_edge, g_rise, g_fall;
    logic unused_d_rise, unused_d_fall, unused_g_prev, unused_g_edge;

    sync_edge #(.STAGES(SYNC_STAGES)) u_d_sync (
        .clk_i   (clk),
        .rst_i   (reset),
        .async_i (d),
        .prev_o  (d_prev),
        .rise_o  (unused_d_rise),
        .fall_o  (unused_d_fall),
        .edge_o  (d_edge)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_g_sync (
        .clk_i   (clk),
        .rst_i   (reset),
        .async_i (g),
        .prev_o  (unused_g_prev),
        .rise_o  (g_rise),
        .fall_o  (g_fall),
        .edge_o  (unused_g_edge)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   setup_run_q, setup_run_d;
    logic [CNT_W-1:0]   setup_lat_q, setup_lat_d;
    logic               cap_lat_q, cap_lat_d;
    logic [CNT_W-1:0]   hold_run_q, hold_run_d;
    logic [CNT_W-1:0]   hold_inc;
    logic               meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0]   setup_cnt_q, setup_cnt_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               setup_viol_q, setup_viol_d;
    logic               hold_viol_q, hold_viol_d;
    logic               cap_val_q, cap_val_d;
    logic [VCNT_W-1:0]  viol_count_q, viol_count_d;
    logic               sv, hv;

    always_comb begin
        // Margin k is the next-cycle count, so a coincident d edge yields 0.
        setup_run_d  = d_edge ? '0 :
                       ((setup_run_q == '1) ? setup_run_q : setup_run_q + CNT_W'(1));
        hold_inc     = (hold_run_q == '1) ? hold_run_q : hold_run_q + CNT_W'(1);
        sv           = setup_lat_q < CNT_W'(SETUP_MIN);
        hv           = hold_inc < CNT_W'(HOLD_MIN);

        state_d      = state_q;
        setup_lat_d  = setup_lat_q;
        cap_lat_d    = cap_lat_q;
        hold_run_d   = hold_run_q;
        meas_valid_d = 1'b0;
        setup_viol_d = 1'b0;
        hold_viol_d  = 1'b0;
        setup_cnt_d  = setup_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        cap_val_d    = cap_val_q;
        viol_count_d = viol_count_q;

        case (state_q)
            IDLE: begin
                if (g_rise) state_d = OPEN;
            end
            OPEN: begin
                if (g_fall) begin
                    setup_lat_d = setup_run_d;
                    cap_lat_d   = d_prev;
                    hold_run_d  = '0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                hold_run_d = hold_inc;
                if (d_edge || g_rise || (hold_inc == CNT_W'(HOLD_MIN))) begin
                    meas_valid_d = 1'b1;
                    setup_cnt_d  = setup_lat_q;
                    hold_cnt_d   = hold_inc;
                    cap_val_d    = cap_lat_q;
                    setup_viol_d = sv;
                    hold_viol_d  = hv;
                    if ((sv || hv) && (viol_count_q != '1))
                        viol_count_d = viol_count_q + VCNT_W'(1);
                    state_d = g_rise ? OPEN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            setup_run_q  <= '1;
            setup_lat_q  <= '0;
            cap_lat_q    <= 1'b0;
            hold_run_q   <= '0;
            meas_valid_q <= 1'b0;
            setup_cnt_q  <= '0;
            hold_cnt_q   <= '0;
            setup_viol_q <= 1'b0;
            hold_viol_q  <= 1'b0;
            cap_val_q    <= 1'b0;
            viol_count_q <= '0;
        end else begin
            state_q      <= state_d;
            setup_run_q  <= setup_run_d;
            setup_lat_q  <= setup_lat_d;
            cap_lat_q    <= cap_lat_d;
            hold_run_q   <= hold_run_d;
            meas_valid_q <= meas_valid_d;
            setup_cnt_q  <= setup_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            setup_viol_q <= setup_viol_d;
            hold_viol_q  <= hold_viol_d;
            cap_val_q    <= cap_val_d;
            viol_count_q <= viol_count_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign setup_cnt  = setup_cnt_q;
    assign hold_cnt   = hold_cnt_q;
    assign setup_viol = setup_viol_q;
    assign hold_viol  = hold_viol_q;
    assign cap_val    = cap_val_q;
    assign viol_count = viol_count_q;

endmodule

// File: tb/tb_setup_hold_monitor.sv
// Directed bench: table of latch windows with hand-computed margins, plus
// saturation, g re-rise and reset-mid-window sequences.
module tb_setup_hold_monitor;

    logic        clk = 1'b0;
    logic        reset, d, g;
    logic        meas_valid, setup_viol, hold_viol, cap_val;
    logic [7:0]  setup_cnt, hold_cnt;
    logic [15:0] viol_count;

    setup_hold_monitor #(
        .CNT_W       (8),
        .SETUP_MIN   (4),
        .HOLD_MIN    (4),
        .SYNC_STAGES (2),
        .VCNT_W      (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d          (d),
        .g          (g),
        .meas_valid (meas_valid),
        .setup_cnt  (setup_cnt),
        .hold_cnt   (hold_cnt),
        .setup_viol (setup_viol),
        .hold_viol  (hold_viol),
        .cap_val    (cap_val),
        .viol_count (viol_count)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned mv_count = 0;
    logic [7:0]  s_setup, s_hold;
    logic        s_sv, s_hv, s_cap;
    logic [15:0] s_vc;

    // Snapshot every measurement pulse away from the active edge.
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            mv_count = mv_count + 1;
            s_setup  = setup_cnt;
            s_hold   = hold_cnt;
            s_sv     = setup_viol;
            s_hv     = hold_viol;
            s_cap    = cap_val;
            s_vc     = viol_count;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_meas(input string tag, input int unsigned mv0,
                              input int unsigned e_setup, input int unsigned e_hold,
                              input logic e_sv, input logic e_hv, input logic e_cap,
                              input int unsigned e_vc);
        check({tag, " meas_count"}, mv_count - mv0, 1);
        check({tag, " setup_cnt"}, {24'd0, s_setup}, e_setup);
        check({tag, " hold_cnt"}, {24'd0, s_hold}, e_hold);
        check({tag, " setup_viol"}, {31'd0, s_sv}, {31'd0, e_sv});
        check({tag, " hold_viol"}, {31'd0, s_hv}, {31'd0, e_hv});
        check({tag, " cap_val"}, {31'd0, s_cap}, {31'd0, e_cap});
        check({tag, " viol_count"}, {16'd0, s_vc}, e_vc);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " meas_valid"}, {31'd0, meas_valid}, 0);
        check({tag, " setup_cnt"}, {24'd0, setup_cnt}, 0);
        check({tag, " hold_cnt"}, {24'd0, hold_cnt}, 0);
        check({tag, " setup_viol"}, {31'd0, setup_viol}, 0);
        check({tag, " hold_viol"}, {31'd0, hold_viol}, 0);
        check({tag, " cap_val"}, {31'd0, cap_val}, 0);
        check({tag, " viol_count"}, {16'd0, viol_count}, 0);
    endtask

    // pre: cycles d is stable before g falls (0 = d toggles with the fall).
    // post: cycles after the fall at which d toggles again (0 = never).
    task automatic run_window(input int unsigned pre, input int unsigned post);
        g = 1'b1;
        cycles(2);
        d = ~d;
        if (pre > 0) cycles(pre);
        g = 1'b0;
        if (post > 0) begin
            cycles(post);
            d = ~d;
        end
        cycles(15);
    endtask

    typedef struct {
        int unsigned pre;
        int unsigned post;
        int unsigned setup;
        int unsigned hold;
        logic        sv;
        logic        hv;
        logic        cap;
        int unsigned vc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int unsigned mv0;

        //           pre post setup hold sv  hv  cap vc
        vecs[0] = '{ 10, 0,  10,   4,   0,  0,  1,  0 };
        vecs[1] = '{ 0,  0,  0,    4,   1,  0,  1,  1 };
        vecs[2] = '{ 8,  2,  8,    2,   0,  1,  1,  2 };
        vecs[3] = '{ 3,  0,  3,    4,   1,  0,  1,  3 };
        vecs[4] = '{ 4,  4,  4,    4,   0,  0,  0,  3 };
        vecs[5] = '{ 6,  1,  6,    1,   0,  1,  0,  4 };
        vecs[6] = '{ 5,  3,  5,    3,   0,  1,  0,  5 };

        reset = 1'b1;
        d     = 1'b0;
        g     = 1'b0;
        cycles(2);
        check_all_zero("reset");
        reset = 1'b0;
        cycles(3);

        for (int i = 0; i < 7; i++) begin
            mv0 = mv_count;
            run_window(vecs[i].pre, vecs[i].post);
            check_meas($sformatf("vec%0d", i), mv0, vecs[i].setup, vecs[i].hold,
                       vecs[i].sv, vecs[i].hv, vecs[i].cap, vecs[i].vc);
        end

        // Long idle saturates the setup counter.
        cycles(300);
        mv0 = mv_count;
        g = 1'b1;
        cycles(3);
        g = 1'b0;
        cycles(15);
        check_meas("saturate", mv0, 255, 4, 1'b0, 1'b0, d, 5);

        // g re-rises 2 cycles after its fall: short hold, then a second window.
        mv0 = mv_count;
        g = 1'b1;
        cycles(2);
        d = ~d;
        cycles(6);
        g = 1'b0;
        cycles(2);
        g = 1'b1;
        cycles(6);
        check_meas("rerise1", mv0, 6, 2, 1'b0, 1'b1, d, 6);
        mv0 = mv_count;
        cycles(2);
        g = 1'b0;
        cycles(15);
        check_meas("rerise2", mv0, 16, 4, 1'b0, 1'b0, d, 6);

        // Reset while in HOLD discards the window.
        g = 1'b1;
        cycles(2);
        d = ~d;
        cycles(5);
        g = 1'b0;
        cycles(4);
        mv0 = mv_count;
        reset = 1'b1;
        cycles(1);
        check_all_zero("midreset");
        cycles(1);
        reset = 1'b0;
        cycles(20);
        check("midreset no_meas", mv_count - mv0, 0);
        d = ~d;
        cycles(20);
        check("idle d toggle no_meas", mv_count - mv0, 0);
        mv0 = mv_count;
        g = 1'b1;
        cycles(2);
        d = ~d;
        cycles(2);
        g = 1'b0;
        cycles(15);
        check_meas("post_reset", mv0, 2, 4, 1'b1, 1'b0, d, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
